// File: rtl/request_encoder.sv
// Registered 4-to-2 request encoder: latches request pulses, grants one per cycle
// (fixed or round-robin priority) on a 2-bit address with an enable/ready handshake.
module request_encoder #(
    parameter bit RR = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    input  logic       ready,
    output logic       addr0,
    output logic       addr1,
    output logic       enable,
    output logic [3:0] pending,
    output logic       merged
);

    logic [3:0] req;
    logic [3:0] clear_mask;
    logic [3:0] cand;
    logic [3:0] pending_next;
    logic [1:0] grant;
    logic [1:0] ptr;
    logic [1:0] scan_base;
    logic [1:0] sel;
    logic       accept;
    logic       slot_free;
    logic       found;
    logic       merged_next;

    assign req       = {in3, in2, in1, in0};
    assign grant     = {addr1, addr0};
    assign accept    = enable & ready;
    assign slot_free = ~enable | accept;

    // A new request on the line being accepted wins over its clear, so it stays pending.
    assign clear_mask   = accept ? (4'b0001 << grant) : 4'b0000;
    assign cand         = pending & ~clear_mask;
    assign pending_next = cand | req;
    assign merged_next  = |(req & cand);

    assign scan_base = RR ? ptr : 2'd0;

    always_comb begin
        sel   = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found && cand[scan_base + 2'(k)]) begin
                sel   = scan_base + 2'(k);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 4'b0000;
            merged  <= 1'b0;
            ptr     <= 2'd0;
            addr0   <= 1'b0;
            addr1   <= 1'b0;
            enable  <= 1'b0;
        end else begin
            pending <= pending_next;
            merged  <= merged_next;
            if (accept) begin
                ptr <= grant + 2'd1;
            end
            // The output slot only reloads when it is empty or being accepted, so a held
            // grant is never preempted.
            if (slot_free) begin
                if (found) begin
                    {addr1, addr0} <= sel;
                    enable         <= 1'b1;
                end else begin
                    {addr1, addr0} <= 2'd0;
                    enable         <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_request_encoder.sv
// Self-checking bench for request_encoder: vector table, hand-written corner cases and
// randomized traffic against a behavioural model, for both round-robin and fixed priority.
module tb_request_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       ready = 1'b0;

    logic       rr_addr0, rr_addr1, rr_enable, rr_merged;
    logic [3:0] rr_pending;
    logic       fx_addr0, fx_addr1, fx_enable, fx_merged;
    logic [3:0] fx_pending;

    int checks = 0;
    int failures = 0;

    // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
    int m_pend[2][4];
    int m_ptr[2];
    int m_en[2];
    int m_g[2];
    int m_mrg[2];

    typedef struct {
        logic [3:0] r;
        logic       rdy;
        logic       en;
        logic [1:0] a;
        logic [3:0] p;
        logic       mg;
    } vec_t;

    vec_t tbl[20];

    always #5 clk = ~clk;

    request_encoder #(.RR(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .in0(req[0]), .in1(req[1]), .in2(req[2]), .in3(req[3]),
        .ready(ready),
        .addr0(rr_addr0), .addr1(rr_addr1), .enable(rr_enable),
        .pending(rr_pending), .merged(rr_merged)
    );

    request_encoder #(.RR(1'b0)) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .in0(req[0]), .in1(req[1]), .in2(req[2]), .in3(req[3]),
        .ready(ready),
        .addr0(fx_addr0), .addr1(fx_addr1), .enable(fx_enable),
        .pending(fx_pending), .merged(fx_merged)
    );

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) m_pend[m][i] = 0;
            m_ptr[m] = 0;
            m_en[m]  = 0;
            m_g[m]   = 0;
            m_mrg[m] = 0;
        end
    endtask

    function automatic int pendWord(input int m);
        int w = 0;
        for (int i = 0; i < 4; i++) w += m_pend[m][i] << i;
        return w;
    endfunction

    // One clock edge of the reference behaviour; priority is chosen as the candidate
    // with the smallest distance from the pointer (RR) or the smallest index (fixed).
    task automatic modelStep(input int m, input logic [3:0] r, input logic rdy);
        int acc, old_g, best, bestkey, key, mrg;
        int cand[4];
        acc   = (m_en[m] != 0 && rdy) ? 1 : 0;
        old_g = m_g[m];
        mrg   = 0;
        for (int i = 0; i < 4; i++) begin
            cand[i] = (m_pend[m][i] != 0 && !(acc != 0 && old_g == i)) ? 1 : 0;
            if (r[i] && cand[i] != 0) mrg = 1;
            m_pend[m][i] = (r[i] || cand[i] != 0) ? 1 : 0;
        end
        m_mrg[m] = mrg;
        if (m_en[m] == 0 || acc != 0) begin
            best = -1;
            bestkey = 4;
            for (int i = 0; i < 4; i++) begin
                if (cand[i] != 0) begin
                    key = (m == 0) ? (i - m_ptr[m] + 4) % 4 : i;
                    if (key < bestkey) begin
                        bestkey = key;
                        best = i;
                    end
                end
            end
            m_en[m] = (best >= 0) ? 1 : 0;
            m_g[m]  = (best >= 0) ? best : 0;
        end
        if (acc != 0) m_ptr[m] = (old_g + 1) % 4;
    endtask

    task automatic compareModels();
        checkOutput("rr_enable",  int'(rr_enable), m_en[0]);
        checkOutput("rr_addr",    int'({rr_addr1, rr_addr0}), m_en[0] != 0 ? m_g[0] : 0);
        checkOutput("rr_pending", int'(rr_pending), pendWord(0));
        checkOutput("rr_merged",  int'(rr_merged), m_mrg[0]);
        checkOutput("fx_enable",  int'(fx_enable), m_en[1]);
        checkOutput("fx_addr",    int'({fx_addr1, fx_addr0}), m_en[1] != 0 ? m_g[1] : 0);
        checkOutput("fx_pending", int'(fx_pending), pendWord(1));
        checkOutput("fx_merged",  int'(fx_merged), m_mrg[1]);
    endtask

    // Drives inputs a little after an edge, lets the next edge sample them, then checks.
    task automatic applyStimulus(input logic [3:0] r, input logic rdy);
        req   = r;
        ready = rdy;
        @(posedge clk);
        if (rst_n) begin
            modelStep(0, r, rdy);
            modelStep(1, r, rdy);
        end
        #1;
        compareModels();
    endtask

    task automatic setVec(input int k, input logic [3:0] r, input logic en,
                          input logic [1:0] a, input logic [3:0] p, input logic mg);
        tbl[k] = '{r, 1'b1, en, a, p, mg};
    endtask

    initial begin
        int hits, stray, merges;
        logic [3:0] dec;

        // Round-robin from reset, a second wrapped round, single request, set-over-clear.
        setVec(0,  4'b1111, 1'b0, 2'd0, 4'b1111, 1'b0);
        setVec(1,  4'b0000, 1'b1, 2'd0, 4'b1111, 1'b0);
        setVec(2,  4'b0000, 1'b1, 2'd1, 4'b1110, 1'b0);
        setVec(3,  4'b0000, 1'b1, 2'd2, 4'b1100, 1'b0);
        setVec(4,  4'b0000, 1'b1, 2'd3, 4'b1000, 1'b0);
        setVec(5,  4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
        setVec(6,  4'b1111, 1'b0, 2'd0, 4'b1111, 1'b0);
        setVec(7,  4'b0000, 1'b1, 2'd0, 4'b1111, 1'b0);
        setVec(8,  4'b0000, 1'b1, 2'd1, 4'b1110, 1'b0);
        setVec(9,  4'b0000, 1'b1, 2'd2, 4'b1100, 1'b0);
        setVec(10, 4'b0000, 1'b1, 2'd3, 4'b1000, 1'b0);
        setVec(11, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
        setVec(12, 4'b0100, 1'b0, 2'd0, 4'b0100, 1'b0);
        setVec(13, 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b0);
        setVec(14, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
        setVec(15, 4'b0100, 1'b0, 2'd0, 4'b0100, 1'b0);
        setVec(16, 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b0);
        setVec(17, 4'b0100, 1'b0, 2'd0, 4'b0100, 1'b0);
        setVec(18, 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b0);
        setVec(19, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);

        modelReset();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_enable",  int'(rr_enable), 0);
        checkOutput("reset_pending", int'(rr_pending), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 20; k++) begin
            applyStimulus(tbl[k].r, tbl[k].rdy);
            checkOutput($sformatf("vec%0d_enable", k),  int'(rr_enable), int'(tbl[k].en));
            checkOutput($sformatf("vec%0d_addr", k),    int'({rr_addr1, rr_addr0}), int'(tbl[k].a));
            checkOutput($sformatf("vec%0d_pending", k), int'(rr_pending), int'(tbl[k].p));
            checkOutput($sformatf("vec%0d_merged", k),  int'(rr_merged), int'(tbl[k].mg));
        end

        $display("[TB] fixed priority");
        applyStimulus(4'b1010, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("fixed_first",  int'({fx_enable, fx_addr1, fx_addr0}), 5);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("fixed_second", int'({fx_enable, fx_addr1, fx_addr0}), 7);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("fixed_idle",   int'(fx_enable), 0);

        $display("[TB] reset mid-handshake");
        applyStimulus(4'b1010, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("prereset_enable",  int'(rr_enable), 1);
        checkOutput("prereset_pending", int'(rr_pending), 10);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_outputs",
                    int'({rr_addr1, rr_addr0, rr_enable, rr_merged, rr_pending}), 0);
        checkOutput("midreset_fx_outputs",
                    int'({fx_addr1, fx_addr0, fx_enable, fx_merged, fx_pending}), 0);
        modelReset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0000, 1'b1);
            checkOutput("postreset_quiet", int'({rr_enable, rr_pending, fx_enable}), 0);
        end

        $display("[TB] back-pressure");
        applyStimulus(4'b0010, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b0000, 1'b0);
            checkOutput("held_out", int'({rr_enable, rr_addr1, rr_addr0}), 5);
        end
        applyStimulus(4'b0001, 1'b0);
        checkOutput("held_no_preempt", int'({rr_enable, rr_addr1, rr_addr0}), 5);
        checkOutput("held_fx",         int'({fx_enable, fx_addr1, fx_addr0}), 5);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("after_accept_01", int'({rr_enable, rr_addr1, rr_addr0}), 4);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("after_accept_00", int'(rr_enable), 0);

        $display("[TB] merge");
        merges = 0;
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        merges += int'(rr_merged);
        applyStimulus(4'b0100, 1'b0);
        merges += int'(rr_merged);
        applyStimulus(4'b0000, 1'b0);
        merges += int'(rr_merged);
        applyStimulus(4'b0100, 1'b0);
        merges += int'(rr_merged);
        checkOutput("merge_count", merges, 2);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("merge_single_grant", int'({rr_enable, rr_pending}), 0);

        $display("[TB] decoder loopback");
        for (int i = 0; i < 4; i++) begin
            hits = 0;
            stray = 0;
            for (int c = 0; c < 5; c++) begin
                applyStimulus(c == 0 ? 4'(1 << i) : 4'b0000, 1'b1);
                dec = rr_enable ? 4'(1 << {rr_addr1, rr_addr0}) : 4'b0000;
                hits  += int'(dec[i]);
                stray += ((dec & ~4'(1 << i)) != 4'b0000) ? 1 : 0;
            end
            checkOutput($sformatf("loop%0d_hits", i), hits, 1);
            checkOutput($sformatf("loop%0d_stray", i), stray, 0);
        end

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            applyStimulus(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                          $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/request_encoder.md
# request_encoder

Registered 4-to-2 request encoder: the sending end of the 2-bit address + enable interface consumed by `structuralDecoder`. It latches request pulses on four input lines, selects one pending request per cycle (fixed or round-robin priority) and presents its index on `addr0`/`addr1` with `enable` as a valid flag. A valid/ready handshake holds the output until the consumer accepts it. Driving a `structuralDecoder` from `addr0`/`addr1`/`enable` reproduces the granted request as a one-hot output.

## Interface
- `RR`, default 1: priority mode.
  - 0 = fixed priority, `in0` highest, then `in1`, `in2`, `in3`.
  - 1 = round-robin starting from the pointer.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `in0`, `in1`, `in2`, `in3`  input  1 each  request lines, sampled every edge; a high sample sets the pending bit.
- `ready`  input  1  the consumer accepts the current output this cycle.
- `addr0`  output  1  LSB of the granted index (registered).
- `addr1`  output  1  MSB of the granted index (registered).
- `enable`  output  1  `addr0`/`addr1` valid (registered).
- `pending`  output  4  outstanding requests, bit i = `in`i (registered); for debug and verification.
- `merged`  output  1  one-cycle pulse: a request arrived while its pending bit was already set.

## Operation
- **State.** `pending[3:0]`, 2-bit round-robin pointer `ptr`, output registers `addr1:addr0` and `enable`.
- **Accept.** Occurs on any edge where `enable && ready`.
- **Pending update**, each edge, evaluated per bit:
  - The set condition is `in`i = 1.
  - The clear condition is an accept with granted index == i.
  - Set has priority over clear: a new request on the accepted line in the accept cycle remains pending.
- **merged.** Asserted for one cycle when any `in`i = 1 while `pending[i]` = 1 and that bit is not being cleared this edge. Requests are not counted; merged requests produce one grant.
- **Candidate set** = `pending` with the bit being accepted this edge masked off. Inputs sampled on the same edge are not candidates until the next edge.
- **Selection:**
  - `RR=0`: lowest set index.
  - `RR=1`: first set index scanning `ptr`, `ptr+1`, … mod 4.
- **Output load.** On an edge where the output slot is free (`enable`=0, or accept), the block does one of two things:
  - If the candidate set is non-empty: load the selected index into `{addr1,addr0}` and set `enable`=1.
  - If the candidate set is empty: set `enable`=0.
- **Hold.** While `enable && !ready`, `addr0`, `addr1` and `enable` stay stable. A newly arriving higher-priority request never preempts the held output.
- **Pointer.** On accept of index g, `ptr` ← (g+1) mod 4, wrapping 3→0. The pointer is unused but still updated when `RR=0`.
- **Idle outputs.** When `enable`=0, `addr0`=`addr1`=0.

## Timing
- **Reset.** `rst_n` low forces, immediately and asynchronously: `pending`=0, `ptr`=0, `addr0`=`addr1`=0, `enable`=0, `merged`=0. State resumes on the first rising edge after deassertion.
- **Reset mid-handshake.** The held output and all pending requests are discarded. No grant is emitted after reset until new requests arrive.
- **Latency.**
  - Request high at edge N sets `pending` at N; `enable`=1 with its index after edge N+1, if the slot is free.
  - Minimum request-to-valid latency is 2 edges.
- **Throughput.** One grant per cycle with `ready` held high; back-to-back grants have no bubble while candidates remain.
- **Boundary cases:**
  - All four pending with `RR=1` and `ready`=1: grant order is `ptr`, `ptr+1`, … over 4 consecutive cycles.
  - Empty after the last accept: `enable` drops on the same edge as that accept.
  - `ready` high while `enable`=0: ignored, no state change.

## Test plan
- **Reset:**
  - Assert `rst_n`=0 mid-cycle with `enable`=1 and `pending`=4'b1010.
  - Required: all outputs 0 immediately; they stay 0 after release with inputs low.
- **Single request:**
  - Pulse `in2` at edge 1, `ready`=1.
  - Required: `pending`=4'b0100 after edge 1; after edge 2 `enable`=1, `addr1`=1, `addr0`=0; after edge 3 `enable`=0 and `pending`=0.
- **Back-pressure:**
  - `in1` pulse with `ready`=0 for 5 cycles, then `in0` pulse while held.
  - Required: `addr`=01 stable and `enable`=1 throughout. After `ready`=1: accept 01, then 00 on the next cycle.
- **Round-robin:**
  - `RR=1`, pulse `in0`–`in3` together at edge 1, `ready`=1.
  - Required: grants 0,1,2,3 on edges 2–5. Re-pulse all four: grants 0,1,2,3 again (`ptr` wrapped 3→0).
- **Fixed priority:**
  - `RR=0`, `in3` and `in1` together, `ready`=1.
  - Required: grant 1 then 3.
- **Set-over-clear and merge:**
  - `in2` high exactly on its accept edge: `pending[2]` stays 1 and 2 is granted again.
  - `in2` high twice while held: `merged` pulses once per extra request and a single grant results.
- **Decoder loopback:**
  - Connect the outputs to `structuralDecoder` and run each single request i.
  - Required: only decoder `out`i high, for exactly one cycle.
